fir_mac_sequencer: RTL



---
 rtl/fir_mac_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/fir_mac_sequencer.sv
// Stereo time-multiplexed FIR sequencer: one shared MAC walks NTAPS taps per channel.
// Define FIR_BYPASS_EN to add a bypass input that forwards samples unfiltered.
// state | meaning
// CLEAR | zero both delay lines, one address per cycle
// IDLE  | wait for an input sample
// MAC   | stream taps through the multiplier
// ROUND | drain last product, add rounding bias, then shift/saturate into output
// OUT   | hold result until the output handshake
module fir_mac_sequencer #(
    parameter int DATA_WIDTH = 24,
    parameter int COEF_WIDTH = 16,
    parameter int NTAPS      = 32,
    parameter int ACC_WIDTH  = 48,
    localparam int AW        = $clog2(NTAPS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [AW-1:0]         coef_addr,
    input  logic [COEF_WIDTH-1:0] coef_data,
`ifdef FIR_BYPASS_EN
    input  logic                  bypass,
`endif
    output logic                  busy
);

    typedef enum logic [2:0] {CLEAR, IDLE, MAC, ROUND, OUT} state_t;

    localparam int PW = DATA_WIDTH + COEF_WIDTH;
    localparam logic [AW-1:0] LAST_IDX = AW'(NTAPS - 1);
    localparam logic signed [ACC_WIDTH-1:0] RND_BIAS =
        {{(ACC_WIDTH-COEF_WIDTH+1){1'b0}}, 1'b1, {(COEF_WIDTH-2){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    state_t state, state_next;
    logic [AW-1:0] cnt;
    logic [1:0] rnd_cnt;
    logic ch;
    logic [AW-1:0] wr_ptr [2];
    logic signed [DATA_WIDTH-1:0] dline [2][NTAPS];
    logic signed [DATA_WIDTH-1:0] sample_reg;
    logic mac_vld;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [PW-1:0] prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] rounded;
    logic [AW-1:0] ptr_cur;
    logic [AW-1:0] rd_idx;
    logic in_hs;
    logic bypass_sel;

`ifdef FIR_BYPASS_EN
    assign bypass_sel = bypass;
`else
    assign bypass_sel = 1'b0;
`endif

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    assign in_hs    = (state == IDLE) && s_axis_tvalid;
    assign ptr_cur  = wr_ptr[ch];
    // Explicit wrap so non-power-of-two tap counts index correctly.
    assign rd_idx   = (ptr_cur >= cnt) ? ptr_cur - cnt : ptr_cur + AW'(NTAPS) - cnt;
    assign prod     = sample_reg * $signed(coef_data);
    assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
    assign shifted  = acc >>> (COEF_WIDTH - 1);

    always_comb begin
        rounded = shifted[DATA_WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            rounded = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            rounded = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        busy          = 1'b1;
        coef_addr     = '0;
        case (state)
            CLEAR: if (cnt == LAST_IDX) state_next = IDLE;
            IDLE: begin
                s_axis_tready = 1'b1;
                busy          = 1'b0;
                if (s_axis_tvalid) state_next = bypass_sel ? OUT : MAC;
            end
            MAC: begin
                coef_addr = cnt;
                if (cnt == LAST_IDX) state_next = ROUND;
            end
            ROUND: if (rnd_cnt == 2'd2) state_next = OUT;
            OUT: begin
                m_axis_tvalid = 1'b1;
                if (m_axis_tready) state_next = IDLE;
            end
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            dline[0][cnt] <= '0;
            dline[1][cnt] <= '0;
        end else if (in_hs) begin
            dline[s_axis_tlast][wr_ptr[s_axis_tlast]] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            rnd_cnt      <= '0;
            ch           <= 1'b0;
            wr_ptr[0]    <= '0;
            wr_ptr[1]    <= '0;
            sample_reg   <= '0;
            mac_vld      <= 1'b0;
            acc          <= '0;
            m_axis_tdata <= '0;
            m_axis_tlast <= 1'b0;
        end else begin
            mac_vld <= (state == MAC);
            case (state)
                CLEAR: cnt <= ptr_inc(cnt);
                IDLE: if (s_axis_tvalid) begin
                    ch      <= s_axis_tlast;
                    cnt     <= '0;
                    rnd_cnt <= '0;
                    acc     <= '0;
                    if (bypass_sel) begin
                        m_axis_tdata         <= s_axis_tdata;
                        m_axis_tlast         <= s_axis_tlast;
                        wr_ptr[s_axis_tlast] <= ptr_inc(wr_ptr[s_axis_tlast]);
                    end
                end
                MAC: begin
                    sample_reg <= dline[ch][rd_idx];
                    cnt        <= ptr_inc(cnt);
                end
                ROUND: begin
                    rnd_cnt <= rnd_cnt + 2'd1;
                    if (rnd_cnt == 2'd2) begin
                        m_axis_tdata <= rounded;
                        m_axis_tlast <= ch;
                        wr_ptr[ch]   <= ptr_inc(ptr_cur);
                    end
                end
                default: ;
            endcase
            // Product of tap k lands one cycle after MAC cycle k; the last one in ROUND step 0.
            if (mac_vld) begin
                acc <= acc + prod_ext;
            end else if ((state == ROUND) && (rnd_cnt == 2'd1)) begin
                acc <= acc + RND_BIAS;
            end
        end
    end

endmodule
